uart_rx_conditioner: RTL and testbench
======================================

Name: uart_rx_conditioner

Overview:
Input conditioning stage between the raw UART0_RX pad and the soc_top uart0_rx_i port, in the soc_clk domain.
- Synchronises the asynchronous pin and rejects glitches shorter than FILT_LEN cycles.
- Detects line-break conditions and counts rejected glitches.
- Provides a pulse-stretched activity flag for an LED.

Parameters:
CLK_HZ, 10000000, soc_clk frequency in Hz
BAUD, 115200, nominal line rate; BIT_CYC = CLK_HZ/BAUD, integer division (86 at defaults)
FILT_LEN, 3, consecutive differing samples needed to accept a level change; must be >= 1
BREAK_BITS, 11, bit times of continuous low that define a break; BREAK_CYC = BREAK_BITS*BIT_CYC (946 at defaults)
ACT_HOLD_CYC, 1000000, activity_o stretch length in cycles; must be >= 1

Ports:
clk_i  in  1  soc clock; all logic on its rising edge
rst_i  in  1  synchronous reset, active-high
rx_pin_i  in  1  raw asynchronous UART RX pad
rx_o  out  1  conditioned RX to the UART core
break_o  out  1  level, high while a break is in progress
break_start_o  out  1  one-cycle pulse at break detection
break_end_o  out  1  one-cycle pulse at break release
activity_o  out  1  high while RX activity was seen within ACT_HOLD_CYC
glitch_cnt_o  out  8  saturating count of rejected glitches

Behaviour:
Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).

Reset:
- While rst_i is high, every register loads its reset value at the next edge: both sync flops=1, rx_o=1, break_o=0, pulses=0, activity_o=0, glitch_cnt_o=0, all counters=0, FSM=IDLE.
- Reset mid-operation aborts everything. No break_end_o pulse is issued for a break cut short by reset.

Synchroniser:
- Two flops, s1 then s2, both reset to 1.

Glitch filter:
- flt_cnt counts consecutive cycles where s2 differs from rx_o.
- When flt_cnt would reach FILT_LEN, rx_o takes the value of s2 and flt_cnt clears.
- If s2 equals rx_o while flt_cnt is nonzero, flt_cnt clears and glitch_cnt_o increments, saturating at 255.
- Total latency from the pin edge to the rx_o change is 2+FILT_LEN edges (5 at defaults).
- Pulses of FILT_LEN-1 or fewer cycles never reach rx_o.

Break FSM (registered outputs):
- IDLE: rx_o=1. When rx_o falls, go to LOW with low_cnt=1.
- LOW: low_cnt increments each cycle rx_o=0.
  - When low_cnt reaches BREAK_CYC, go to BREAK: break_o=1 and break_start_o pulses for exactly that cycle.
  - When rx_o rises before that, go to IDLE and clear low_cnt.
- BREAK: low_cnt holds (saturated). When rx_o rises, go to IDLE next cycle: break_o=0 and break_end_o pulses for one cycle.
- A normal frame (max 9 low bit times) never triggers a break.
- The low_cnt width is $clog2(BREAK_CYC+1).

Activity:
- On any rx_o falling edge, act_cnt loads ACT_HOLD_CYC. Otherwise it decrements while nonzero.
- activity_o = (act_cnt != 0), registered.
- A retrigger while active reloads the counter (extends the hold).
- A falling edge in the same cycle as the counter reaches 0 reloads it; activity_o stays high.

No combinational path from rx_pin_i to any output.

Test Plan:
1. Reset: rx_pin_i=1, rst_i high 5 cycles, release -> rx_o=1, break_o/break_start_o/break_end_o/activity_o=0, glitch_cnt_o=0. Assert rst_i with rx_pin_i=0 -> same values held during reset.
2. Clean edge: rx_pin_i 1->0 before edge N -> rx_o low at edge N+4 (5th edge), activity_o high the following cycle. Pin back to 1 -> rx_o high 5 edges later, no glitch count.
3. Glitch: rx_pin_i low for 1, then for 2 cycles, separated by 20 idle cycles -> rx_o stays 1, glitch_cnt_o=2. Apply 300 such glitches -> glitch_cnt_o saturates at 255.
4. Frame: send 0x55 8N1 at BIT_CYC=86 cycles/bit -> rx_o reproduces the waveform delayed 5 cycles, edge for edge. break_o stays 0, activity_o high. With ACT_HOLD_CYC=100 override, activity_o drops 100 cycles after the last falling edge.
5. Break: rx_pin_i low for 1200 cycles -> break_start_o single pulse 946 cycles after rx_o falls, break_o high. Pin high -> break_end_o single pulse and break_o=0 one cycle after rx_o rises.
6. Reset mid-break: assert rst_i for 3 cycles while break_o=1 and the pin stays low -> outputs cleared, no break_end_o pulse. After release, rx_o falls 5 edges later and break_start_o recurs 946 cycles after that.

Source files
------------

// File: rtl/uart_rx_conditioner.sv
// Input conditioning for the UART RX pad: two-flop synchroniser, glitch filter,
// line-break detector and a pulse-stretched activity flag, all on clk_i.
module uart_rx_conditioner #(
   parameter int unsigned CLK_HZ       = 10000000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned FILT_LEN     = 3,
   parameter int unsigned BREAK_BITS   = 11,
   parameter int unsigned ACT_HOLD_CYC = 1000000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_pin_i,
   output logic       rx_o,
   output logic       break_o,
   output logic       break_start_o,
   output logic       break_end_o,
   output logic       activity_o,
   output logic [7:0] glitch_cnt_o
);

   localparam int unsigned BIT_CYC   = CLK_HZ / BAUD;
   localparam int unsigned BREAK_CYC = BREAK_BITS * BIT_CYC;
   localparam int unsigned FW        = $clog2(FILT_LEN + 1);
   localparam int unsigned LW        = $clog2(BREAK_CYC + 1);
   localparam int unsigned AW        = $clog2(ACT_HOLD_CYC + 1);

   typedef enum logic [1:0] {IDLE, LOW, BREAK} state_t;

   logic          r_s1, r_s2, r_rx;
   logic [FW-1:0] r_flt_cnt;
   logic [7:0]    r_glitch;
   state_t        r_state;
   logic [LW-1:0] r_low_cnt;
   logic          r_break, r_bstart, r_bend;
   logic [AW-1:0] r_act_cnt;
   logic          r_act;
   logic          w_accept, w_fall;

   // A change is accepted on the FILT_LEN-th consecutive differing sample
   assign w_accept = (r_s2 != r_rx) && (r_flt_cnt == FW'(FILT_LEN - 1));
   assign w_fall   = w_accept && !r_s2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1      <= 1'b1;
         r_s2      <= 1'b1;
         r_rx      <= 1'b1;
         r_flt_cnt <= '0;
         r_glitch  <= '0;
      end else begin
         r_s1 <= rx_pin_i;
         r_s2 <= r_s1;
         if (w_accept) begin
            r_rx      <= r_s2;
            r_flt_cnt <= '0;
         end else if (r_s2 != r_rx) begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
         end else if (r_flt_cnt != '0) begin
            r_flt_cnt <= '0;
            if (r_glitch != 8'hFF) r_glitch <= r_glitch + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_low_cnt <= '0;
         r_break   <= 1'b0;
         r_bstart  <= 1'b0;
         r_bend    <= 1'b0;
      end else begin
         r_bstart <= 1'b0;
         r_bend   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!r_rx) begin
                  r_low_cnt <= LW'(1);
                  if (BREAK_CYC == 1) begin
                     r_state  <= BREAK;
                     r_break  <= 1'b1;
                     r_bstart <= 1'b1;
                  end else begin
                     r_state <= LOW;
                  end
               end
            end
            LOW: begin
               if (r_rx) begin
                  r_state   <= IDLE;
                  r_low_cnt <= '0;
               end else begin
                  r_low_cnt <= r_low_cnt + 1'b1;
                  if (r_low_cnt + 1'b1 == LW'(BREAK_CYC)) begin
                     r_state  <= BREAK;
                     r_break  <= 1'b1;
                     r_bstart <= 1'b1;
                  end
               end
            end
            BREAK: begin
               if (r_rx) begin
                  r_state   <= IDLE;
                  r_low_cnt <= '0;
                  r_break   <= 1'b0;
                  r_bend    <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_low_cnt <= '0;
               r_break   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_act_cnt <= '0;
         r_act     <= 1'b0;
      end else begin
         if (w_fall)                r_act_cnt <= AW'(ACT_HOLD_CYC);
         else if (r_act_cnt != '0)  r_act_cnt <= r_act_cnt - 1'b1;
         r_act <= (r_act_cnt != '0);
      end
   end

   assign rx_o          = r_rx;
   assign break_o       = r_break;
   assign break_start_o = r_bstart;
   assign break_end_o   = r_bend;
   assign activity_o    = r_act;
   assign glitch_cnt_o  = r_glitch;

endmodule

// File: tb/tb_uart_rx_conditioner.sv
// Randomised bench for uart_rx_conditioner against an event/time-based reference model.
module tb_uart_rx_conditioner;

   localparam int FL   = 3;
   localparam int BC   = 11 * (10000000 / 115200);
   localparam int HOLD = 100;
   localparam int BIT  = 10000000 / 115200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pin = 1'b1;
   logic       rx_o, break_o, break_start_o, break_end_o, activity_o;
   logic [7:0] glitch_cnt_o;

   int errors = 0;
   int checks = 0;

   uart_rx_conditioner #(
      .CLK_HZ(10000000), .BAUD(115200), .FILT_LEN(FL), .BREAK_BITS(11), .ACT_HOLD_CYC(HOLD)
   ) dut (
      .clk_i(clk), .rst_i(rst), .rx_pin_i(pin), .rx_o(rx_o), .break_o(break_o),
      .break_start_o(break_start_o), .break_end_o(break_end_o),
      .activity_o(activity_o), .glitch_cnt_o(glitch_cnt_o)
   );

   always #5 clk = ~clk;

   // Reference: pin delayed through two samples, then a sliding window of the last
   // FL samples; break and activity derived from recorded rx_o edge times.
   int  t = 0;
   bit  m_valid = 0;
   bit  m_s1, m_s2, m_rx, m_prev;
   bit  m_win [FL];
   int  m_fall, m_rise, m_lf, m_glitch;
   bit  m_brk, m_bs, m_be, m_act;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step(input bit p, input bit r);
      bit v, acc, brk_new;
      int age;
      if (r) begin
         m_s1 = 1; m_s2 = 1; m_rx = 1; m_prev = 1;
         for (int i = 0; i < FL; i++) m_win[i] = 1;
         m_fall = -1; m_rise = -1; m_lf = -1; m_glitch = 0;
         m_brk = 0; m_bs = 0; m_be = 0; m_act = 0;
      end else begin
         age   = t - 1 - m_lf;
         m_act = (m_lf >= 0) && (age >= 0) && (age < HOLD);
         v    = m_s2;
         m_s2 = m_s1;
         m_s1 = p;
         for (int i = 0; i < FL - 1; i++) m_win[i] = m_win[i+1];
         m_win[FL-1] = v;
         acc = 1;
         for (int i = 0; i < FL; i++) if (m_win[i] == m_rx) acc = 0;
         if (acc) begin
            m_rx = !m_rx;
            if (!m_rx) begin m_fall = t; m_lf = t; end
            else m_rise = t;
         end else if (v == m_rx && m_prev != m_rx && m_glitch < 255) begin
            m_glitch++;
         end
         m_prev  = v;
         brk_new = (m_fall >= 0) && (m_rise < m_fall || m_rise == t) && (t - m_fall >= BC);
         m_bs    = brk_new && (t - m_fall == BC);
         m_be    = m_brk && !brk_new;
         m_brk   = brk_new;
      end
      t++;
   endtask

   task automatic drive(input bit p, input bit r, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (m_valid) begin
            chk("rx_o", 32'(rx_o), 32'(m_rx));
            chk("break_o", 32'(break_o), 32'(m_brk));
            chk("break_start_o", 32'(break_start_o), 32'(m_bs));
            chk("break_end_o", 32'(break_end_o), 32'(m_be));
            chk("activity_o", 32'(activity_o), 32'(m_act));
            chk("glitch_cnt_o", 32'(glitch_cnt_o), 32'(m_glitch));
         end
         pin = p;
         rst = r;
         model_step(p, r);
         if (r) m_valid = 1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      drive(0, 0, BIT);
      for (int i = 0; i < 8; i++) drive(b[i], 0, BIT);
      drive(1, 0, BIT);
   endtask

   task automatic now_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      @(posedge clk);
      #1;
      chk(tag, obs, exp);
   endtask

   initial begin
      int n;
      drive(1, 1, 5);
      drive(1, 0, 10);
      drive(0, 1, 3);
      drive(1, 0, 10);
      // clean edges
      drive(0, 0, 30);
      drive(1, 0, 30);
      // glitches of 1 and 2 cycles, then random ones until saturation
      drive(0, 0, 1);
      drive(1, 0, 20);
      drive(0, 0, 2);
      drive(1, 0, 20);
      now_chk("glitch_two", 32'(glitch_cnt_o), 32'd2);
      for (int i = 0; i < 298; i++) begin
         drive(0, 0, $urandom_range(1, 2));
         drive(1, 0, 20);
      end
      now_chk("glitch_sat", 32'(glitch_cnt_o), 32'd255);
      drive(1, 1, 2);
      drive(1, 0, 10);
      // frames, then idle long enough for activity to lapse
      send_byte(8'h55);
      drive(1, 0, 150);
      for (int i = 0; i < 3; i++) begin
         send_byte(8'($urandom));
         drive(1, 0, $urandom_range(0, 200));
      end
      // random noise with short runs
      n = 0;
      while (n < 2000) begin
         int len;
         len = $urandom_range(1, 6);
         drive(1'($urandom_range(0, 1)), 0, len);
         n += len;
      end
      drive(1, 0, 50);
      // break and break-length boundaries
      drive(0, 0, 1200);
      now_chk("break_held", 32'(break_o), 32'd1);
      drive(1, 0, 50);
      for (int i = BC - 2; i <= BC + 1; i++) begin
         drive(0, 0, i);
         drive(1, 0, 30);
      end
      // reset in the middle of a break
      drive(0, 0, 1100);
      now_chk("break_before_rst", 32'(break_o), 32'd1);
      drive(0, 1, 3);
      now_chk("break_after_rst", 32'(break_o), 32'd0);
      drive(0, 0, 1200);
      now_chk("break_again", 32'(break_o), 32'd1);
      drive(1, 0, 200);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
